// File: rtl/pattern_sequencer.sv
// Playback and host-write controller for the 8-buffer pattern store.
// Streams a programmed run of fields out of one buffer and services single-byte host writes.
module pattern_sequencer #(
   parameter int buffer_size  = 22,
   parameter int buffer_width = 8,
   parameter int no_bufs      = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic                    stop,
   input  logic                    loop,
   input  logic [2:0]              play_buf,
   input  logic [4:0]              play_len,
   input  logic                    pat_ready,
   input  logic [buffer_width-1:0] field_byte,
   input  logic                    wr_req,
   input  logic [2:0]              wr_buf,
   input  logic [4:0]              wr_field,
   input  logic [buffer_width-1:0] wr_data,
   output logic [no_bufs-1:0]      bufp,
   output logic [no_bufs-1:0]      buffer_select,
   output logic [buffer_size-1:0]  fieldp,
   output logic [buffer_size-1:0]  fieldwp,
   output logic [buffer_width-1:0] field_in,
   output logic                    field_write,
   output logic [buffer_width-1:0] pat_out,
   output logic                    pat_valid,
   output logic                    busy,
   output logic                    done,
   output logic                    wr_ack,
   output logic                    wr_err
);

   // state    | meaning
   // st_idle  | waiting for start or a host write request
   // st_play  | streaming fields from the selected buffer
   // st_write | single cycle presenting one host byte to the store
   localparam logic [1:0] st_idle  = 2'd0;
   localparam logic [1:0] st_play  = 2'd1;
   localparam logic [1:0] st_write = 2'd2;

   localparam logic [4:0] field_lim = 5'(buffer_size);
   localparam logic [buffer_size-1:0] fp_first = buffer_size'(1);
   localparam logic [no_bufs-1:0] bp_first = no_bufs'(1);

   logic [1:0] state;
   logic [4:0] idx;
   logic [4:0] len;
   logic [4:0] len_clamped;
   logic       loop_q;

   always_comb begin
      len_clamped = play_len;
      if (play_len == 5'd0)
         len_clamped = 5'd1;
      else if (play_len > field_lim)
         len_clamped = field_lim;
   end

   assign busy = (state != st_idle);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= st_idle;
         idx           <= 5'd0;
         len           <= 5'd1;
         loop_q        <= 1'b0;
         bufp          <= bp_first;
         buffer_select <= bp_first;
         fieldp        <= fp_first;
         fieldwp       <= '0;
         field_in      <= '0;
         field_write   <= 1'b0;
         pat_out       <= '0;
         pat_valid     <= 1'b0;
         done          <= 1'b0;
         wr_ack        <= 1'b0;
         wr_err        <= 1'b0;
      end else begin
         pat_valid   <= 1'b0;
         done        <= 1'b0;
         wr_ack      <= 1'b0;
         wr_err      <= 1'b0;
         field_write <= 1'b0;
         fieldwp     <= '0;
         case (state)
            st_idle: begin
               // start outranks a pending write; the request simply waits
               if (start) begin
                  loop_q        <= loop;
                  len           <= len_clamped;
                  idx           <= 5'd0;
                  fieldp        <= fp_first;
                  bufp          <= bp_first << play_buf;
                  buffer_select <= bp_first << play_buf;
                  state         <= st_play;
               end else if (wr_req) begin
                  bufp     <= bp_first << wr_buf;
                  field_in <= wr_data;
                  wr_ack   <= 1'b1;
                  if (wr_field >= field_lim) begin
                     wr_err <= 1'b1;
                  end else begin
                     field_write <= 1'b1;
                     fieldwp     <= fp_first << wr_field;
                  end
                  state <= st_write;
               end
            end
            st_play: begin
               if (stop) begin
                  idx    <= 5'd0;
                  fieldp <= fp_first;
                  state  <= st_idle;
               end else if (pat_ready) begin
                  pat_out   <= field_byte;
                  pat_valid <= 1'b1;
                  if (idx == len - 5'd1) begin
                     idx    <= 5'd0;
                     fieldp <= fp_first;
                     if (!loop_q) begin
                        done  <= 1'b1;
                        state <= st_idle;
                     end
                  end else begin
                     idx    <= idx + 5'd1;
                     fieldp <= fieldp << 1;
                  end
               end
            end
            st_write: state <= st_idle;
            default:  state <= st_idle;
         endcase
      end
   end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed bench for pattern_sequencer with a behavioural pattern store on field_byte.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_pattern_sequencer;

   logic        clk, rst_n, start, stop, loop, pat_ready, wr_req;
   logic [2:0]  play_buf, wr_buf;
   logic [4:0]  play_len, wr_field;
   logic [7:0]  field_byte, wr_data, field_in, pat_out;
   logic [7:0]  bufp, buffer_select;
   logic [21:0] fieldp, fieldwp;
   logic        field_write, pat_valid, busy, done, wr_ack, wr_err;

   logic [7:0] mem [8][22];
   int tests = 0;
   int failed = 0;

   pattern_sequencer dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop(loop),
      .play_buf(play_buf), .play_len(play_len), .pat_ready(pat_ready),
      .field_byte(field_byte), .wr_req(wr_req), .wr_buf(wr_buf),
      .wr_field(wr_field), .wr_data(wr_data), .bufp(bufp),
      .buffer_select(buffer_select), .fieldp(fieldp), .fieldwp(fieldwp),
      .field_in(field_in), .field_write(field_write), .pat_out(pat_out),
      .pat_valid(pat_valid), .busy(busy), .done(done), .wr_ack(wr_ack),
      .wr_err(wr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      int bi, fi;
      bi = 0;
      fi = 0;
      for (int i = 0; i < 8; i++) if (bufp[i]) bi = i;
      for (int j = 0; j < 22; j++) if (fieldp[j]) fi = j;
      field_byte = mem[bi][fi];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [7:0]  exp4 [4];
      logic        rdy_seq [5];
      logic        val_seq [5];
      logic [7:0]  byte_seq [5];
      logic [21:0] last_fp;
      logic [7:0]  last_byte;
      int          cnt, ack_in_play;
      logic        got_done;

      exp4     = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
      rdy_seq  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      val_seq  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      byte_seq = '{8'hF0, 8'hF0, 8'hF1, 8'hF0, 8'hF1};

      for (int b = 0; b < 8; b++)
         for (int f = 0; f < 22; f++)
            mem[b][f] = {3'(b), 5'(f)};
      for (int f = 0; f < 4; f++) mem[3][f] = exp4[f];
      mem[1][0] = 8'hF0;
      mem[1][1] = 8'hF1;

      rst_n = 1'b0; start = 0; stop = 0; loop = 0; pat_ready = 0; wr_req = 0;
      play_buf = 0; play_len = 0; wr_buf = 0; wr_field = 0; wr_data = 0;
      repeat (2) tick();
      chk("rst_bufp", 32'(bufp), 32'h01);
      chk("rst_bsel", 32'(buffer_select), 32'h01);
      chk("rst_fieldp", 32'(fieldp), 32'h1);
      chk("rst_fieldwp", 32'(fieldwp), 32'h0);
      chk("rst_field_in", 32'(field_in), 32'h0);
      chk("rst_outs", 32'({field_write, pat_valid, busy, done, wr_ack, wr_err}), 32'h0);
      chk("rst_pat_out", 32'(pat_out), 32'h0);
      rst_n = 1'b1;
      tick();

      // buffer 3, four fields, no loop
      start = 1; play_buf = 3; play_len = 4; loop = 0; pat_ready = 1;
      tick();
      start = 0;
      chk("p3_bufp", 32'(bufp), 32'h08);
      chk("p3_bsel", 32'(buffer_select), 32'h08);
      chk("p3_busy", 32'(busy), 32'h1);
      chk("p3_fieldp0", 32'(fieldp), 32'h1);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("p3_byte", 32'(pat_out), 32'(exp4[i]));
         chk("p3_valid", 32'(pat_valid), 32'h1);
         chk("p3_done", 32'(done), (i == 3) ? 32'h1 : 32'h0);
      end
      chk("p3_busy_end", 32'(busy), 32'h0);
      chk("p3_fieldp_end", 32'(fieldp), 32'h1);
      chk("p3_bufp_hold", 32'(bufp), 32'h08);
      tick();
      chk("p3_done_clr", 32'({done, pat_valid}), 32'h0);

      // buffer 1, two fields looping, with a stalled cycle
      start = 1; play_buf = 1; play_len = 2; loop = 1;
      tick();
      start = 0;
      for (int i = 0; i < 5; i++) begin
         pat_ready = rdy_seq[i];
         tick();
         chk("lp_valid", 32'(pat_valid), 32'(val_seq[i]));
         chk("lp_byte", 32'(pat_out), 32'(byte_seq[i]));
         chk("lp_busy", 32'({busy, done}), 32'h2);
      end
      stop = 1; pat_ready = 1;
      tick();
      stop = 0;
      chk("stop_state", 32'({busy, done, pat_valid}), 32'h0);
      chk("stop_nocap", 32'(pat_out), 32'hF1);
      tick();
      chk("stop_nodone", 32'(done), 32'h0);

      // zero length clamps to one field
      start = 1; play_buf = 2; play_len = 0; loop = 0; pat_ready = 1;
      tick();
      start = 0;
      tick();
      chk("len0_byte", 32'(pat_out), 32'h40);
      chk("len0_done", 32'({done, pat_valid, busy}), 32'h6);

      // oversize length clamps to the full buffer
      start = 1; play_buf = 4; play_len = 30;
      tick();
      start = 0;
      cnt = 0; last_fp = '0; last_byte = '0; got_done = 0;
      for (int i = 0; i < 40 && !got_done; i++) begin
         if (busy) last_fp = fieldp;
         tick();
         if (pat_valid) begin
            cnt++;
            last_byte = pat_out;
         end
         if (done) got_done = 1;
      end
      chk("len30_done", 32'(got_done), 32'h1);
      chk("len30_count", 32'(cnt), 32'd22);
      chk("len30_lastfp", 32'(last_fp), 32'h200000);
      chk("len30_lastbyte", 32'(last_byte), 32'h95);
      pat_ready = 0;
      tick();

      // host write, valid field then out-of-range field
      wr_req = 1; wr_buf = 5; wr_field = 21; wr_data = 8'h5A;
      tick();
      chk("wr_strobe", 32'({field_write, wr_ack, wr_err}), 32'h6);
      chk("wr_bufp", 32'(bufp), 32'h20);
      chk("wr_fieldwp", 32'(fieldwp), 32'h200000);
      chk("wr_data", 32'(field_in), 32'h5A);
      chk("wr_bsel", 32'(buffer_select), 32'h10);
      wr_req = 0;
      tick();
      chk("wr_after", 32'({field_write, wr_ack, busy}), 32'h0);
      chk("wr_after_fwp", 32'(fieldwp), 32'h0);
      wr_req = 1; wr_field = 22;
      tick();
      chk("wr_err", 32'({field_write, wr_ack, wr_err}), 32'h3);
      chk("wr_err_fwp", 32'(fieldwp), 32'h0);
      wr_req = 0;
      tick();

      // write requested during playback waits for the end of play
      start = 1; play_buf = 3; play_len = 4; loop = 0; pat_ready = 1;
      tick();
      start = 0;
      wr_req = 1; wr_buf = 6; wr_field = 7; wr_data = 8'hC3;
      got_done = 0; ack_in_play = 0;
      for (int i = 0; i < 20 && !got_done; i++) begin
         tick();
         if (wr_ack) ack_in_play++;
         if (done) got_done = 1;
      end
      chk("pend_done", 32'(got_done), 32'h1);
      chk("pend_noack", 32'(ack_in_play), 32'd0);
      tick();
      chk("pend_ack", 32'({field_write, wr_ack, wr_err}), 32'h6);
      chk("pend_data", 32'(field_in), 32'hC3);
      chk("pend_fwp", 32'(fieldwp), 32'h80);
      chk("pend_bufp", 32'(bufp), 32'h40);
      wr_req = 0;
      tick();

      // start and write request together: start wins
      start = 1; play_buf = 2; play_len = 1; wr_req = 1;
      wr_buf = 7; wr_field = 0; wr_data = 8'h3C;
      tick();
      start = 0;
      chk("sw_play", 32'({busy, wr_ack}), 32'h2);
      chk("sw_bufp", 32'(bufp), 32'h04);
      tick();
      chk("sw_done", 32'({done, wr_ack}), 32'h2);
      tick();
      chk("sw_ack", 32'({field_write, wr_ack}), 32'h3);
      chk("sw_data", 32'(field_in), 32'h3C);
      chk("sw_wbufp", 32'(bufp), 32'h80);
      chk("sw_fwp", 32'(fieldwp), 32'h1);
      wr_req = 0;
      tick();

      // asynchronous reset in the middle of a looping playback
      start = 1; play_buf = 5; play_len = 10; loop = 1; pat_ready = 1;
      tick();
      start = 0;
      repeat (2) tick();
      chk("mid_busy", 32'({busy, pat_valid}), 32'h3);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_bufp", 32'(bufp), 32'h01);
      chk("arst_fieldp", 32'(fieldp), 32'h1);
      chk("arst_flags", 32'({pat_valid, busy}), 32'h0);
      chk("arst_pat_out", 32'(pat_out), 32'h0);
      tick();
      rst_n = 1'b1;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
